// File: rtl/dds_phase_ctrl.sv
// Phase-accumulator front end for the DDS sine generator: turns FTW/POW/sweep config into sine ROM addresses.
// Latency: accept -> first accumulate 1 clk -> rom_addr 1 clk later; data_valid trails rom_addr by ROM_LATENCY.
// Backpressure: cfg_ready is low only while a sweep is in progress; the address stream itself is never stalled.
//
// Ports:
//   clk, rst                 single clock shared with the ROM; synchronous active-high reset
//   en                       advance enable; low freezes phase, FTW and sweep progress
//   cfg_valid / cfg_ready    configuration handshake (cfg_ftw, cfg_pow, cfg_step, cfg_ftw_end)
//   rom_addr                 registered ROM address (phase MSBs + offset)
//   data_valid               ROM read data is valid this cycle
//   wrap                     accumulator carry pulse, aligned with the rom_addr it produced
//   sweep_done               one-cycle pulse when the FTW reaches the sweep end value
module dds_phase_ctrl #(
    parameter int ACC_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ACC_WIDTH-1:0]  cfg_ftw,
    input  logic [ADDR_WIDTH-1:0] cfg_pow,
    input  logic [ACC_WIDTH-1:0]  cfg_step,
    input  logic [ACC_WIDTH-1:0]  cfg_ftw_end,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  data_valid,
    output logic                  wrap,
    output logic                  sweep_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TONE  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic [ACC_WIDTH-1:0]    ftw_q;
    logic [ACC_WIDTH-1:0]    ftw_d;
    logic [ACC_WIDTH-1:0]    step_q;
    logic [ACC_WIDTH-1:0]    end_q;
    logic [ADDR_WIDTH-1:0]   pow_q;
    logic                    carry_q;
    logic                    addr_vld;
    logic                    done_d;
    logic                    accept;
    logic                    advance;
    logic [ACC_WIDTH:0]      acc_sum;
    logic [ACC_WIDTH:0]      sweep_sum;
    logic [ROM_LATENCY-1:0]  vld_dly;

    assign cfg_ready  = (state_q != SWEEP);
    assign accept     = cfg_valid & cfg_ready;
    assign advance    = en & (state_q != IDLE);
    assign acc_sum    = {1'b0, acc_q} + {1'b0, ftw_q};
    // One extra bit so a large step can never wrap the FTW past the end value.
    assign sweep_sum  = {1'b0, ftw_q} + {1'b0, step_q};
    assign data_valid = vld_dly[ROM_LATENCY-1];

    always_comb begin
        state_d = state_q;
        ftw_d   = ftw_q;
        done_d  = 1'b0;
        if (accept) begin
            ftw_d = cfg_ftw;
            if (cfg_step == '0) begin
                state_d = TONE;
            end else if (cfg_ftw >= cfg_ftw_end) begin
                // Sweep already at or past its end: finish immediately.
                state_d = TONE;
                done_d  = 1'b1;
            end else begin
                state_d = SWEEP;
            end
        end else if ((state_q == SWEEP) && en) begin
            if (sweep_sum >= {1'b0, end_q}) begin
                ftw_d   = end_q;
                state_d = TONE;
                done_d  = 1'b1;
            end else begin
                ftw_d = sweep_sum[ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            ftw_q      <= '0;
            step_q     <= '0;
            end_q      <= '0;
            pow_q      <= '0;
            carry_q    <= 1'b0;
            rom_addr   <= '0;
            wrap       <= 1'b0;
            addr_vld   <= 1'b0;
            sweep_done <= 1'b0;
            vld_dly    <= '0;
        end else begin
            state_q    <= state_d;
            ftw_q      <= ftw_d;
            sweep_done <= done_d;
            if (accept) begin
                pow_q  <= cfg_pow;
                step_q <= cfg_step;
                end_q  <= cfg_ftw_end;
            end
            // Accumulator is never cleared on accept so phase stays continuous.
            // carry_q remembers whether the current acc value came from a carry;
            // it is reported with the valid address built from that acc value.
            if (advance) begin
                acc_q   <= acc_sum[ACC_WIDTH-1:0];
                carry_q <= acc_sum[ACC_WIDTH];
            end
            rom_addr <= acc_q[ACC_WIDTH-1 -: ADDR_WIDTH] + pow_q;
            wrap     <= advance & carry_q;
            addr_vld <= advance;
            vld_dly[0] <= addr_vld;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                vld_dly[i] <= vld_dly[i-1];
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Randomised + directed bench for dds_phase_ctrl with a scoreboard.
// The driver predicts each clock edge from a phase/sweep reference model and queues the expectation;
// the monitor pops and compares on the opposite clock edge and pairs every data_valid with its address.
module tb_dds_phase_ctrl;

    localparam int AW = 32;
    localparam int DW = 10;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_ftw;
    logic [DW-1:0] cfg_pow;
    logic [AW-1:0] cfg_step;
    logic [AW-1:0] cfg_ftw_end;
    logic [DW-1:0] rom_addr;
    logic          data_valid;
    logic          wrap;
    logic          sweep_done;

    always #5 clk = ~clk;

    dds_phase_ctrl #(
        .ACC_WIDTH  (AW),
        .ADDR_WIDTH (DW),
        .ROM_LATENCY(L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ftw    (cfg_ftw),
        .cfg_pow    (cfg_pow),
        .cfg_step   (cfg_step),
        .cfg_ftw_end(cfg_ftw_end),
        .rom_addr   (rom_addr),
        .data_valid (data_valid),
        .wrap       (wrap),
        .sweep_done (sweep_done)
    );

    typedef struct {
        int          edge_n;
        logic [DW-1:0] addr;
        logic        wrap;
        logic        sd;
        logic        dv;
        logic        rdy;
    } exp_t;

    typedef struct {
        int          edge_n;
        logic [DW-1:0] addr;
    } ae_t;

    exp_t exp_q[$];
    ae_t  addr_q[$];

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase is kept as an unwrapped running total; the accumulator is its low AW bits
    // and a wrap is a change in the number of whole turns. A sweep is described by
    // its start FTW, step and precomputed length ceil((end - start) / step).
    int            m_mode;      // 0 idle, 1 fixed tone, 2 sweeping
    logic [63:0]   m_total;
    logic [63:0]   m_prev;
    logic [AW-1:0] m_ftw;
    logic [AW-1:0] m_ftw0;
    logic [AW-1:0] m_step;
    logic [AW-1:0] m_end;
    logic [DW-1:0] m_pow;
    logic [63:0]   m_len;
    logic [63:0]   m_k;
    int            m_pend[$];

    task automatic model_edge(input int e);
        exp_t        x;
        ae_t         a;
        logic        emit;
        logic        ready;
        logic [63:0] turn_len;
        turn_len = 64'h1_0000_0000;
        x.edge_n = e;
        x.dv     = 1'b0;
        x.wrap   = 1'b0;
        x.sd     = 1'b0;
        if (rst) begin
            m_mode  = 0;
            m_total = '0;
            m_prev  = '0;
            m_ftw   = '0;
            m_step  = '0;
            m_end   = '0;
            m_pow   = '0;
            m_pend.delete();
            // Addresses whose data_valid would land on or after this edge are lost.
            while (addr_q.size() > 0 && addr_q[$].edge_n >= e - L) void'(addr_q.pop_back());
            x.addr = '0;
            x.rdy  = 1'b1;
        end else begin
            ready  = (m_mode != 2);
            emit   = en && (m_mode != 0);
            x.addr = DW'(((m_total % turn_len) >> (AW - DW)) + 64'(m_pow));
            if (emit) begin
                x.wrap   = ((m_total / turn_len) != (m_prev / turn_len));
                a.edge_n = e;
                a.addr   = x.addr;
                addr_q.push_back(a);
                m_pend.push_back(e);
            end
            if (m_pend.size() > 0 && m_pend[0] == e - L) begin
                x.dv = 1'b1;
                void'(m_pend.pop_front());
            end
            if (emit) begin
                m_prev  = m_total;
                m_total = m_total + 64'(m_ftw);
            end
            if (cfg_valid && ready) begin
                m_pow  = cfg_pow;
                m_step = cfg_step;
                m_end  = cfg_ftw_end;
                m_ftw  = cfg_ftw;
                m_ftw0 = cfg_ftw;
                if (cfg_step == 0) begin
                    m_mode = 1;
                end else if (cfg_ftw >= cfg_ftw_end) begin
                    m_mode = 1;
                    x.sd   = 1'b1;
                end else begin
                    m_mode = 2;
                    m_k    = 0;
                    m_len  = (64'(cfg_ftw_end - cfg_ftw) + 64'(cfg_step) - 1) / 64'(cfg_step);
                end
            end else if (m_mode == 2 && en) begin
                m_k = m_k + 1;
                if (m_k >= m_len) begin
                    m_ftw  = m_end;
                    m_mode = 1;
                    x.sd   = 1'b1;
                end else begin
                    m_ftw = AW'(64'(m_ftw0) + m_k * 64'(m_step));
                end
            end
            x.rdy = (m_mode != 2);
        end
        exp_q.push_back(x);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit r, input bit e, input bit v, input logic [AW-1:0] f,
                         input logic [DW-1:0] p, input logic [AW-1:0] s, input logic [AW-1:0] fe);
        rst         = r;
        en          = e;
        cfg_valid   = v;
        cfg_ftw     = f;
        cfg_pow     = p;
        cfg_step    = s;
        cfg_ftw_end = fe;
        model_edge(edge_cnt + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) drive(1'b0, e, 1'b0, '0, '0, '0, '0);
    endtask

    // ---------------- monitor ----------------
    logic [DW-1:0] hist [0:7];

    initial begin : monitor
        exp_t x;
        ae_t  a;
        forever begin
            @(negedge clk);
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = rom_addr;
            while (exp_q.size() > 0 && exp_q[0].edge_n <= edge_cnt) begin
                x = exp_q.pop_front();
                if (x.edge_n != edge_cnt) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_expectation: edge %0d checked at %0d", x.edge_n, edge_cnt);
                end else begin
                    chk("rom_addr",   64'(rom_addr),   64'(x.addr));
                    chk("wrap",       64'(wrap),       64'(x.wrap));
                    chk("sweep_done", 64'(sweep_done), 64'(x.sd));
                    chk("data_valid", 64'(data_valid), 64'(x.dv));
                    chk("cfg_ready",  64'(cfg_ready),  64'(x.rdy));
                end
            end
            if (data_valid === 1'b1) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_data_valid at edge %0d: got 1, expected 0", edge_cnt);
                end else begin
                    a = addr_q.pop_front();
                    chk("valid_timing", 64'(edge_cnt), 64'(a.edge_n + L));
                    chk("valid_addr",   64'(hist[L]),  64'(a.addr));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [AW-1:0] f;
        logic [AW-1:0] s;
        bit            r;
        bit            e;
        bit            v;
        m_mode  = 0;
        m_total = '0;
        m_prev  = '0;
        m_ftw   = '0;
        m_ftw0  = '0;
        m_step  = '0;
        m_end   = '0;
        m_pow   = '0;
        m_len   = '0;
        m_k     = '0;

        repeat (3) drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);

        // Fixed tone: one address step per cycle, one wrap per 1024 cycles.
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0000, 10'd0, 32'd0, 32'd0);
        run(1100, 1'b1);

        // Phase offset, then reconfigure without resetting the accumulator.
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        drive(1'b0, 1'b1, 1'b1, 32'd0, 10'd256, 32'd0, 32'd0);
        run(20, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0000, 10'd1000, 32'd0, 32'd0);
        run(40, 1'b1);

        // Linear sweep: 4 enabled cycles, then tone at the end FTW.
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0000, 10'd0, 32'h0010_0000, 32'h0080_0000);
        run(12, 1'b1);

        // Same sweep with en dropped for 5 cycles; config offered while busy must be refused.
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0000, 10'd7, 32'h0010_0000, 32'h0080_0000);
        run(1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 32'h0123_4567, 10'd9, 32'd5, 32'hFFFF_FFFF);
        run(10, 1'b1);

        // Clamp: the FTW sum would overflow AW bits, must clamp to end after one step.
        drive(1'b0, 1'b1, 1'b1, 32'h9000_0000, 10'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run(5, 1'b1);

        // Degenerate start: ftw already above end.
        drive(1'b0, 1'b1, 1'b1, 32'h0100_0000, 10'd5, 32'h0000_0010, 32'h0080_0000);
        run(5, 1'b1);

        // Reset in the middle of a long sweep, then restart.
        drive(1'b0, 1'b1, 1'b1, 32'd0, 10'd3, 32'h0001_0000, 32'h0100_0000);
        run(10, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 32'h0200_0000, 10'd1, 32'd0, 32'd0);
        run(3, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0000, 10'd0, 32'd0, 32'd0);
        run(20, 1'b1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom % 400) == 0;
            e = ($urandom % 6) != 0;
            v = ($urandom % 15) == 0;
            f = $urandom;
            if ($urandom % 2 == 0) f = f >> 8;
            s = ($urandom % 3 == 0) ? 32'd0 : 32'($urandom_range(32'h0100_0000, 32'h2000_0000));
            drive(r, e, v, f, 10'($urandom), s, 32'($urandom));
        end

        // Drain so every emitted address has had its data_valid slot.
        run(L + 4, 1'b0);
        @(negedge clk);
        #1;
        chk("pending_expectations", 64'(exp_q.size()), 64'd0);
        chk("undelivered_addresses", 64'(addr_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_phase_ctrl.md
# dds_phase_ctrl

Phase-accumulator front end of the DDS sine generator. Takes a frequency tuning word (FTW), a phase offset (POW) and an optional linear frequency sweep through a valid/ready configuration port. Produces the registered address bus that drives the sine-wave lookup ROM (10-bit address, 8-bit data), plus a `data_valid` strobe aligned with the ROM's read data. Sits directly upstream of the ROM: `rom_addr` connects to the ROM `addr` input.

## Interface
- `ACC_WIDTH`, 32 — phase accumulator and FTW width.
- `ADDR_WIDTH`, 10 — ROM address width; must be ≤ `ACC_WIDTH`.
- `ROM_LATENCY`, 1 — ROM read latency in clocks, ≥ 1; sets the `data_valid` delay.
- `clk`  in  1  — single clock, shared with the ROM.
- `rst`  in  1  — reset, synchronous and active-high.
- `en`  in  1  — advance enable; when low, all phase and sweep state holds.
- `cfg_valid`  in  1  — configuration offered.
- `cfg_ready`  out  1  — configuration can be accepted.
- `cfg_ftw`  in  ACC_WIDTH  — start FTW.
- `cfg_pow`  in  ADDR_WIDTH  — phase offset in ROM-address units.
- `cfg_step`  in  ACC_WIDTH  — FTW increment per enabled cycle; 0 means fixed tone.
- `cfg_ftw_end`  in  ACC_WIDTH  — sweep end FTW (unsigned).
- `rom_addr`  out  ADDR_WIDTH  — registered ROM address.
- `data_valid`  out  1  — ROM `rd_data` is valid this cycle.
- `wrap`  out  1  — one-cycle pulse, aligned with `rom_addr`, when the accumulator carried out.
- `sweep_done`  out  1  — one-cycle pulse when the sweep reaches `cfg_ftw_end`.

## Operation
- **States:**
  - IDLE: no configuration loaded; accumulator held at 0.
  - TONE: fixed FTW.
  - SWEEP: FTW ramping.
- **`cfg_ready`** is combinational: 1 in IDLE and TONE, 0 in SWEEP.
- **Accept** occurs when `cfg_valid & cfg_ready`. On the next edge, the ftw, pow, step and end registers load.
  - The accumulator is not cleared on accept, so the phase is continuous.
  - If `cfg_step == 0`, go to TONE.
  - Else if `cfg_ftw >= cfg_ftw_end`, go to TONE, force ftw to `cfg_ftw`, and pulse `sweep_done` next cycle.
  - Else go to SWEEP.
- **TONE/SWEEP with `en` = 1, each cycle:**
  - `acc <= acc + ftw`, using the old ftw, modulo 2^ACC_WIDTH. The carry-out is registered into `wrap`.
- **SWEEP only:**
  - Compute `ftw + step` in ACC_WIDTH+1 bits, so there is no overflow.
  - If the result is ≥ end: `ftw <= end`, state goes to TONE, and `sweep_done` is 1 in the following cycle.
  - Otherwise: `ftw <= ftw + step`.
- **`en` = 0:** acc, ftw and state hold; `wrap` = 0; no new valid address.
- **Address:** `rom_addr <= acc[ACC_WIDTH-1 -: ADDR_WIDTH] + pow`, modulo 2^ADDR_WIDTH, registered every cycle in all states. In IDLE this gives `rom_addr = pow`.
- **`addr_vld`** (internal) is the registered value of `en & (state != IDLE)`. `data_valid` is `addr_vld` delayed by ROM_LATENCY cycles through a shift register.
- **Reset values (all outputs and state):**
  - state IDLE; acc, ftw, pow, step and end all 0.
  - `rom_addr` 0, `data_valid` 0, `wrap` 0, `sweep_done` 0; delay line cleared.
  - `cfg_ready` 1 from the first cycle after reset.
- **Reset mid-sweep:** all of the above apply on the next edge. In-flight `data_valid` is dropped, and no `sweep_done` is emitted.
- **Simultaneous `rst` and accept:** `rst` wins and the configuration is discarded.

## Timing
- **Accept to address:** accept at edge N; the first accumulate happens at edge N+1; `rom_addr` reflects it at edge N+2.
- **Enable to data:** `en` high at edge K gives `addr_vld` at K+1 and `data_valid` at K+1+ROM_LATENCY. Each `data_valid` pairs with the `rom_addr` presented ROM_LATENCY cycles earlier.
- **Address pipeline:** `rom_addr` trails the accumulator by one register stage. `wrap` is in the same stage as `rom_addr`.
- **Throughput:** one address per enabled cycle, with no bubbles.
- **Sweep length:** `sweep_done` fires exactly ceil((end − ftw0)/step) enabled cycles after SWEEP entry, plus one cycle.

## Test plan
- **Fixed tone.** Reset, then accept ftw = 0x0040_0000, step = 0, pow = 0, with `en` = 1.
  - `rom_addr` steps 0,1,2,…,1023,0 by 1 per cycle.
  - `wrap` pulses once per 1024 cycles, aligned with `rom_addr` = 0.
  - `data_valid` rises ROM_LATENCY cycles after the first valid address.
- **Phase offset.** Accept ftw = 0, pow = 256.
  - `rom_addr` holds at 256 permanently.
  - Re-configure with pow = 1000 and ftw = 0x0040_0000: the address sequence continues 1000,1001,…,1023,0 with no accumulator reset.
- **Sweep.** Accept ftw = 0x0040_0000, step = 0x0010_0000, end = 0x0080_0000.
  - `cfg_ready` is 0 for 4 enabled cycles.
  - `sweep_done` pulses once, then the state is TONE.
  - `rom_addr` then increments by 2 per cycle.
  - `cfg_ready` returns to 1.
- **Sweep clamp and degenerate start.**
  - Accept ftw = 0x9000_0000, step = 0x8000_0000, end = 0xFFFF_FFFF: no wrap of ftw; clamps to end after 1 cycle, with `sweep_done`.
  - Accept ftw ≥ end: immediate TONE, `sweep_done` pulses, and `cfg_ready` never drops.
- **Enable gating.** During a sweep, drop `en` for 5 cycles.
  - `rom_addr`, ftw and the sweep count freeze.
  - `data_valid` goes low for exactly 5 cycles, shifted by 1+ROM_LATENCY.
  - `sweep_done` timing extends by 5 cycles.
- **Reset mid-sweep.** Assert `rst` for 1 cycle during SWEEP.
  - Next cycle: `rom_addr` = 0, `data_valid` = 0, `cfg_ready` = 1, `sweep_done` never pulses.
  - A following accept restarts from acc = 0.
